// File: rtl/wb_sdram_mport.sv
// wb_sdram_mport: N-port Wishbone pipelined front end for wb_sdram.
// Ports are arbitrated combinationally onto one downstream master; the
// index of each accepted port goes into an in-flight ID FIFO so that the
// in-order acks from the slave are routed back to the right port with no
// added latency in either direction.
//
// Handshake: a downstream transfer is accepted in a cycle where
// m_wb_stb && !m_wb_stall; an upstream port's request is accepted in the
// same cycle (it sees s_wb_stall low while granted). Acks are single-cycle
// pulses that complete in acceptance order and never arrive in the accept
// cycle.
//
// Build option: define WB_SDRAM_MPORT_FIXED_PRIO_EN to replace the
// round-robin arbiter with fixed priority (lowest port index wins).
module wb_sdram_mport #(
   parameter int N_PORTS         = 2,
   parameter int ADDR_BITS       = 23,
   parameter int DATA_BYTES      = 2,
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic                              clk,
   input  logic                              sreset,
   input  logic [N_PORTS*ADDR_BITS-1:0]      s_wb_addr,
   input  logic [N_PORTS*DATA_BYTES*8-1:0]   s_wb_dat_m2s,
   input  logic [N_PORTS-1:0]                s_wb_we,
   input  logic [N_PORTS-1:0]                s_wb_stb,
   output logic [N_PORTS-1:0]                s_wb_ack,
   output logic [N_PORTS-1:0]                s_wb_stall,
   output logic [DATA_BYTES*8-1:0]           s_wb_dat_s2m,
   output logic [ADDR_BITS-1:0]              m_wb_addr,
   output logic [DATA_BYTES*8-1:0]           m_wb_dat_m2s,
   output logic                              m_wb_we,
   output logic                              m_wb_stb,
   input  logic [DATA_BYTES*8-1:0]           m_wb_dat_s2m,
   input  logic                              m_wb_ack,
   input  logic                              m_wb_stall,
   output logic                              err_ack
);

   localparam int DW    = DATA_BYTES * 8;
   localparam int ID_W  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
   localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTSTANDING);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);

   // Per-port views of the flat request buses.
   logic [ADDR_BITS-1:0] addr_arr [N_PORTS];
   logic [DW-1:0]        dat_arr  [N_PORTS];

   for (genvar k = 0; k < N_PORTS; k++) begin : g_unpack
      assign addr_arr[k] = s_wb_addr[k*ADDR_BITS +: ADDR_BITS];
      assign dat_arr[k]  = s_wb_dat_m2s[k*DW +: DW];
   end

   logic [ID_W-1:0]  grant;
   logic             any_req;
   logic             fifo_full;
   logic             fifo_empty;
   logic             accept;
   logic             pop;
   logic [ID_W-1:0]  head_id;

   logic [ID_W-1:0]  id_mem [MAX_OUTSTANDING];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] fifo_count;

`ifdef WB_SDRAM_MPORT_FIXED_PRIO_EN
   // Fixed priority: scan downward so the lowest requesting index wins.
   always_comb begin
      grant   = '0;
      any_req = 1'b0;
      for (int j = N_PORTS - 1; j >= 0; j--) begin
         if (s_wb_stb[j]) begin
            grant   = ID_W'(j);
            any_req = 1'b1;
         end
      end
   end
`else
   localparam logic [ID_W-1:0] LAST_PORT = ID_W'(N_PORTS - 1);

   logic [ID_W-1:0] last_grant;
   logic [ID_W-1:0] hi_grant;
   logic [ID_W-1:0] lo_grant;
   logic            hi_found;
   logic            lo_found;

   // Round-robin: first requester above last_grant, else wrap to the
   // first requester at or below it.
   always_comb begin
      hi_grant = '0;
      lo_grant = '0;
      hi_found = 1'b0;
      lo_found = 1'b0;
      for (int j = 0; j < N_PORTS; j++) begin
         if (s_wb_stb[j] && !hi_found && (ID_W'(j) > last_grant)) begin
            hi_found = 1'b1;
            hi_grant = ID_W'(j);
         end
         if (s_wb_stb[j] && !lo_found && (ID_W'(j) <= last_grant)) begin
            lo_found = 1'b1;
            lo_grant = ID_W'(j);
         end
      end
      any_req = hi_found || lo_found;
      grant   = hi_found ? hi_grant : lo_grant;
   end

   // Remember the port of the last accepted transfer; reset makes port 0 next.
   always_ff @(posedge clk) begin
      if (sreset) begin
         last_grant <= LAST_PORT;
      end else if (accept) begin
         last_grant <= grant;
      end
   end
`endif

   assign fifo_full  = (fifo_count == FULL_CNT);
   assign fifo_empty = (fifo_count == '0);
   assign head_id    = id_mem[rd_ptr];

   // Downstream request path: pure mux of the granted port, gated by
   // reset and by the in-flight limit.
   always_comb begin
      m_wb_stb     = !sreset && any_req && s_wb_stb[grant] && !fifo_full;
      m_wb_addr    = addr_arr[grant];
      m_wb_dat_m2s = dat_arr[grant];
      m_wb_we      = s_wb_we[grant];
   end

   assign accept       = m_wb_stb && !m_wb_stall;
   assign pop          = !sreset && m_wb_ack && !fifo_empty;
   assign s_wb_dat_s2m = m_wb_dat_s2m;

   // Everyone stalls except the granted port, which follows the
   // downstream stall and the FIFO-full condition.
   always_comb begin
      s_wb_stall = '1;
      if (!sreset && any_req) begin
         s_wb_stall[grant] = m_wb_stall || fifo_full;
      end
   end

   // Route an ack to the port at the head of the in-flight FIFO.
   always_comb begin
      s_wb_ack = '0;
      if (pop) begin
         s_wb_ack[head_id] = 1'b1;
      end
   end

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   // ID storage needs no reset: only entries between the pointers are read.
   always_ff @(posedge clk) begin
      if (accept) begin
         id_mem[wr_ptr] <= grant;
      end
   end

   // FIFO pointers and occupancy; push and pop in one cycle cancel out.
   always_ff @(posedge clk) begin
      if (sreset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (accept) begin
            wr_ptr <= ptr_next(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= ptr_next(rd_ptr);
         end
         case ({accept, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // Sticky flag for an ack that arrives with nothing in flight.
   always_ff @(posedge clk) begin
      if (sreset) begin
         err_ack <= 1'b0;
      end else if (m_wb_ack && fifo_empty) begin
         err_ack <= 1'b1;
      end
   end

endmodule

// File: tb/tb_wb_sdram_mport.sv
// Bench for wb_sdram_mport. The bench plays both the upstream masters and
// the downstream slave (a 16-word memory that acks one cycle after
// acceptance when enabled). Expected acks are queued as requests are
// driven and compared when the slave acks. dut_a has a 2-deep in-flight
// FIFO; dut_b shares its stimulus with a 4-deep FIFO and is only examined
// in the reset-with-three-in-flight sequence.
module tb_wb_sdram_mport;

   localparam int NP = 2;
   localparam int AW = 23;
   localparam int DW = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              sreset;
   logic [AW-1:0]     p_addr [NP];
   logic [DW-1:0]     p_dat  [NP];
   logic [NP-1:0]     p_we;
   logic [NP-1:0]     s_stb;
   logic [NP*AW-1:0]  s_wb_addr;
   logic [NP*DW-1:0]  s_wb_dat_m2s;
   logic [DW-1:0]     m_wb_dat_s2m;
   logic              m_wb_ack;
   logic              m_wb_stall;

   assign s_wb_addr    = {p_addr[1], p_addr[0]};
   assign s_wb_dat_m2s = {p_dat[1], p_dat[0]};

   logic [NP-1:0] s_wb_ack_a, s_wb_stall_a, s_wb_ack_b, s_wb_stall_b;
   logic [DW-1:0] s_wb_dat_s2m_a, s_wb_dat_s2m_b, m_wb_dat_m2s_a, m_wb_dat_m2s_b;
   logic [AW-1:0] m_wb_addr_a, m_wb_addr_b;
   logic          m_wb_we_a, m_wb_we_b, m_wb_stb_a, m_wb_stb_b, err_ack_a, err_ack_b;

   wb_sdram_mport #(.N_PORTS(NP), .ADDR_BITS(AW), .DATA_BYTES(2), .MAX_OUTSTANDING(2)) dut_a (
      .clk(clk), .sreset(sreset),
      .s_wb_addr(s_wb_addr), .s_wb_dat_m2s(s_wb_dat_m2s), .s_wb_we(p_we), .s_wb_stb(s_stb),
      .s_wb_ack(s_wb_ack_a), .s_wb_stall(s_wb_stall_a), .s_wb_dat_s2m(s_wb_dat_s2m_a),
      .m_wb_addr(m_wb_addr_a), .m_wb_dat_m2s(m_wb_dat_m2s_a), .m_wb_we(m_wb_we_a), .m_wb_stb(m_wb_stb_a),
      .m_wb_dat_s2m(m_wb_dat_s2m), .m_wb_ack(m_wb_ack), .m_wb_stall(m_wb_stall),
      .err_ack(err_ack_a)
   );

   wb_sdram_mport #(.N_PORTS(NP), .ADDR_BITS(AW), .DATA_BYTES(2), .MAX_OUTSTANDING(4)) dut_b (
      .clk(clk), .sreset(sreset),
      .s_wb_addr(s_wb_addr), .s_wb_dat_m2s(s_wb_dat_m2s), .s_wb_we(p_we), .s_wb_stb(s_stb),
      .s_wb_ack(s_wb_ack_b), .s_wb_stall(s_wb_stall_b), .s_wb_dat_s2m(s_wb_dat_s2m_b),
      .m_wb_addr(m_wb_addr_b), .m_wb_dat_m2s(m_wb_dat_m2s_b), .m_wb_we(m_wb_we_b), .m_wb_stb(m_wb_stb_b),
      .m_wb_dat_s2m(m_wb_dat_s2m), .m_wb_ack(m_wb_ack), .m_wb_stall(m_wb_stall),
      .err_ack(err_ack_b)
   );

   int total = 0;
   int bad   = 0;

   // Scoreboard entry: {is_read, port[3:0], read_data[15:0]}
   logic [20:0] exp_q [$];
   logic [15:0] slv_q [$];
   logic [15:0] ref_mem [16];
   logic [15:0] slv_mem [16];
   logic        ack_en;
   logic        force_ack;
   logic        exp_err;
   logic        err_pend;

   typedef struct packed {
      logic [1:0] stb;
      logic       mstall;
      logic       exp_mstb;
      logic [1:0] exp_stall;
      logic       exp_grant;
   } vec_t;

   vec_t tbl [11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Queue the ack expected for the port about to be accepted.
   task automatic expect_accept(input int port);
      logic [3:0] a;
      a = p_addr[port][3:0];
      if (p_we[port]) begin
         ref_mem[a] = p_dat[port];
         exp_q.push_back({1'b0, 4'(port), 16'h0000});
      end else begin
         exp_q.push_back({1'b1, 4'(port), ref_mem[a]});
      end
   endtask

   // Sampled at the falling edge: slave capture plus ack/err checks.
   task automatic monitor();
      logic [20:0] e;
      logic [1:0]  oh;
      if (m_wb_stb_a && !m_wb_stall) begin
         if (m_wb_we_a) begin
            slv_mem[m_wb_addr_a[3:0]] = m_wb_dat_m2s_a;
            slv_q.push_back(16'h0000);
         end else begin
            slv_q.push_back(slv_mem[m_wb_addr_a[3:0]]);
         end
      end
      if (m_wb_ack) begin
         if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            oh = 2'b01 << e[19:16];
            chk("ack_route", 32'(s_wb_ack_a), 32'(oh));
            if (e[20]) chk("ack_data", 32'(s_wb_dat_s2m_a), 32'(e[15:0]));
         end else begin
            chk("stray_no_ack", 32'(s_wb_ack_a), 32'h0);
            err_pend = 1'b1;
         end
      end else begin
         chk("idle_no_ack", 32'(s_wb_ack_a), 32'h0);
      end
      chk("err_ack", 32'(err_ack_a), 32'(exp_err));
   endtask

   task automatic slave_drive();
      if ((ack_en && slv_q.size() > 0) || force_ack) begin
         m_wb_ack = 1'b1;
         if (slv_q.size() > 0) m_wb_dat_s2m = slv_q.pop_front();
         else                  m_wb_dat_s2m = 16'hBAD0;
      end else begin
         m_wb_ack     = 1'b0;
         m_wb_dat_s2m = 16'($urandom);
      end
   endtask

   task automatic to_negedge();
      @(negedge clk);
      monitor();
   endtask

   task automatic to_next();
      @(posedge clk);
      if (sreset) begin
         exp_err  = 1'b0;
         err_pend = 1'b0;
      end else if (err_pend) begin
         exp_err  = 1'b1;
         err_pend = 1'b0;
      end
      #1;
      slave_drive();
   endtask

   task automatic step();
      to_negedge();
      to_next();
   endtask

   task automatic do_reset();
      sreset    = 1'b1;
      s_stb     = '0;
      ack_en    = 1'b0;
      force_ack = 1'b0;
      step();
      slv_q.delete();
      exp_q.delete();
      sreset    = 1'b0;
   endtask

   initial begin
      sreset       = 1'b1;
      s_stb        = 2'b11;
      p_we         = '0;
      p_addr[0]    = 23'd3;
      p_addr[1]    = 23'd7;
      p_dat[0]     = 16'h0000;
      p_dat[1]     = 16'h0000;
      m_wb_stall   = 1'b0;
      m_wb_ack     = 1'b0;
      m_wb_dat_s2m = 16'h0000;
      ack_en       = 1'b0;
      force_ack    = 1'b0;
      exp_err      = 1'b0;
      err_pend     = 1'b0;
      for (int i = 0; i < 16; i++) begin
         ref_mem[i] = 16'hA000 + 16'(i);
         slv_mem[i] = 16'hA000 + 16'(i);
      end

      // Reset state: requests present but everything gated off.
      to_negedge();
      chk("rst_mstb", 32'(m_wb_stb_a), 32'h0);
      chk("rst_stall", 32'(s_wb_stall_a), 32'h3);
      chk("rst_ack", 32'(s_wb_ack_a), 32'h0);
      to_next();
      sreset = 1'b0;
      s_stb  = '0;
      step();

      // Arbitration table: {stb, m_stall, exp m_stb, exp s_stall, exp grant}
`ifdef WB_SDRAM_MPORT_FIXED_PRIO_EN
      tbl[0]  = '{2'b11, 1'b0, 1'b1, 2'b10, 1'b0};
      tbl[1]  = '{2'b11, 1'b0, 1'b1, 2'b10, 1'b0};
      tbl[2]  = '{2'b11, 1'b0, 1'b1, 2'b10, 1'b0};
      tbl[3]  = '{2'b11, 1'b0, 1'b1, 2'b10, 1'b0};
      tbl[4]  = '{2'b10, 1'b1, 1'b1, 2'b11, 1'b1};
      tbl[5]  = '{2'b10, 1'b0, 1'b1, 2'b01, 1'b1};
      tbl[6]  = '{2'b01, 1'b0, 1'b1, 2'b10, 1'b0};
      tbl[7]  = '{2'b00, 1'b0, 1'b0, 2'b11, 1'b0};
      tbl[8]  = '{2'b11, 1'b1, 1'b1, 2'b11, 1'b0};
      tbl[9]  = '{2'b11, 1'b0, 1'b1, 2'b10, 1'b0};
      tbl[10] = '{2'b01, 1'b0, 1'b1, 2'b10, 1'b0};
`else
      tbl[0]  = '{2'b11, 1'b0, 1'b1, 2'b10, 1'b0};
      tbl[1]  = '{2'b11, 1'b0, 1'b1, 2'b01, 1'b1};
      tbl[2]  = '{2'b11, 1'b0, 1'b1, 2'b10, 1'b0};
      tbl[3]  = '{2'b11, 1'b0, 1'b1, 2'b01, 1'b1};
      tbl[4]  = '{2'b10, 1'b1, 1'b1, 2'b11, 1'b1};
      tbl[5]  = '{2'b10, 1'b0, 1'b1, 2'b01, 1'b1};
      tbl[6]  = '{2'b01, 1'b0, 1'b1, 2'b10, 1'b0};
      tbl[7]  = '{2'b00, 1'b0, 1'b0, 2'b11, 1'b0};
      tbl[8]  = '{2'b11, 1'b1, 1'b1, 2'b11, 1'b1};
      tbl[9]  = '{2'b11, 1'b0, 1'b1, 2'b01, 1'b1};
      tbl[10] = '{2'b01, 1'b0, 1'b1, 2'b10, 1'b0};
`endif
      ack_en = 1'b1;
      for (int i = 0; i < 11; i++) begin
         s_stb      = tbl[i].stb;
         m_wb_stall = tbl[i].mstall;
         if (tbl[i].exp_mstb && !tbl[i].mstall) expect_accept(int'(tbl[i].exp_grant));
         to_negedge();
         chk("tbl_mstb", 32'(m_wb_stb_a), 32'(tbl[i].exp_mstb));
         chk("tbl_stall", 32'(s_wb_stall_a), 32'(tbl[i].exp_stall));
         if (tbl[i].exp_mstb)
            chk("tbl_grant_addr", 32'(m_wb_addr_a), 32'(p_addr[tbl[i].exp_grant]));
         to_next();
      end
      s_stb      = '0;
      m_wb_stall = 1'b0;
      step();
      step();

      // Random single-requester traffic through the memory model.
      for (int i = 0; i < 12; i++) begin
         int port;
         port         = int'($urandom_range(0, 1));
         p_we[port]   = 1'($urandom_range(0, 1));
         p_addr[port] = 23'($urandom_range(0, 15));
         p_dat[port]  = 16'($urandom_range(0, 65535));
         s_stb        = 2'b01 << port;
         m_wb_stall   = ($urandom_range(0, 3) == 0);
         if (!m_wb_stall) expect_accept(port);
         to_negedge();
         chk("rnd_addr", 32'(m_wb_addr_a), 32'(p_addr[port]));
         chk("rnd_we", 32'(m_wb_we_a), 32'(p_we[port]));
         to_next();
      end
      s_stb      = '0;
      m_wb_stall = 1'b0;
      step();
      step();

      // Port 1 writes 5555 to addr 0, then port 0 reads it back.
      p_we[1] = 1'b1; p_addr[1] = 23'd0; p_dat[1] = 16'h5555;
      p_we[0] = 1'b0; p_addr[0] = 23'd0;
      ref_mem[0] = 16'h0000; slv_mem[0] = 16'h0000;
      s_stb = 2'b10;
      expect_accept(1);
      to_negedge();
      chk("wr_we", 32'(m_wb_we_a), 32'h1);
      chk("wr_dat", 32'(m_wb_dat_m2s_a), 32'h5555);
      to_next();
      s_stb = 2'b01;
      expect_accept(0);
      to_negedge();
      chk("wr_ack_p1_only", 32'(s_wb_ack_a), 32'h2);
      chk("rd_we", 32'(m_wb_we_a), 32'h0);
      to_next();
      s_stb = '0;
      to_negedge();
      chk("rd_ack_p0", 32'(s_wb_ack_a), 32'h1);
      chk("rd_dat", 32'(s_wb_dat_s2m_a), 32'h5555);
      to_next();
      p_we = '0; p_addr[0] = 23'd3; p_addr[1] = 23'd7;
      step();

      // Ack and new accept in the same cycle at occupancy 1.
      s_stb = 2'b01;
      expect_accept(0);
      to_negedge();
      chk("occ_start", 32'(dut_a.fifo_count), 32'h0);
      to_next();
      s_stb = 2'b10;
      expect_accept(1);
      to_negedge();
      chk("occ_one", 32'(dut_a.fifo_count), 32'h1);
      chk("sim_ack_p0", 32'(s_wb_ack_a), 32'h1);
      chk("sim_accept", 32'(m_wb_stb_a), 32'h1);
      to_next();
      s_stb = '0;
      to_negedge();
      chk("occ_kept", 32'(dut_a.fifo_count), 32'h1);
      chk("ack_p1_next", 32'(s_wb_ack_a), 32'h2);
      to_next();
      to_negedge();
      chk("occ_zero", 32'(dut_a.fifo_count), 32'h0);
      to_next();

      // In-flight limit of 2 with acks withheld: third request waits.
      ack_en = 1'b0;
      s_stb  = 2'b01;
      for (int i = 0; i < 2; i++) begin
         expect_accept(0);
         to_negedge();
         chk("lim_mstb_on", 32'(m_wb_stb_a), 32'h1);
         chk("lim_stall_off", 32'(s_wb_stall_a), 32'h2);
         to_next();
      end
      for (int i = 0; i < 2; i++) begin
         to_negedge();
         chk("full_mstb", 32'(m_wb_stb_a), 32'h0);
         chk("full_stall", 32'(s_wb_stall_a), 32'h3);
         if (i == 1) ack_en = 1'b1;
         to_next();
      end
      to_negedge();
      chk("full_ack_mstb", 32'(m_wb_stb_a), 32'h0);
      chk("full_ack_stall", 32'(s_wb_stall_a), 32'h3);
      chk("full_ack_p0", 32'(s_wb_ack_a), 32'h1);
      to_next();
      expect_accept(0);
      to_negedge();
      chk("third_accept", 32'(m_wb_stb_a), 32'h1);
      chk("third_stall", 32'(s_wb_stall_a), 32'h2);
      to_next();
      s_stb = '0;
      step();
      step();
      step();

      // Reset with three transfers in flight (4-deep instance).
      do_reset();
      s_stb = 2'b01;
      for (int i = 0; i < 3; i++) begin
         to_negedge();
         chk("b_mstb", 32'(m_wb_stb_b), 32'h1);
         to_next();
      end
      sreset = 1'b1;
      s_stb  = 2'b11;
      to_negedge();
      chk("b_inflight3", 32'(dut_b.fifo_count), 32'h3);
      chk("b_rst_mstb", 32'(m_wb_stb_b), 32'h0);
      chk("b_rst_stall", 32'(s_wb_stall_b), 32'h3);
      chk("b_rst_ack", 32'(s_wb_ack_b), 32'h0);
      to_next();
      slv_q.delete();
      exp_q.delete();
      sreset     = 1'b0;
      m_wb_stall = 1'b1;
      to_negedge();
      chk("b_post_empty", 32'(dut_b.fifo_count), 32'h0);
      chk("a_post_empty", 32'(dut_a.fifo_count), 32'h0);
      chk("b_first_p0", 32'(m_wb_addr_b), 32'(p_addr[0]));
      chk("a_first_p0", 32'(m_wb_addr_a), 32'(p_addr[0]));
      chk("b_err_clr", 32'(err_ack_b), 32'h0);
      to_next();
      s_stb      = '0;
      m_wb_stall = 1'b0;
      step();

      // Stray ack with nothing in flight sets the sticky error.
      force_ack = 1'b1;
      to_negedge();
      to_next();
      force_ack = 1'b0;
      to_negedge();
      chk("stray_sack", 32'(s_wb_ack_a), 32'h0);
      chk("stray_err_before", 32'(err_ack_a), 32'h0);
      to_next();
      for (int i = 0; i < 3; i++) begin
         to_negedge();
         chk("err_sticky", 32'(err_ack_a), 32'h1);
         to_next();
      end
      do_reset();
      to_negedge();
      chk("err_cleared", 32'(err_ack_a), 32'h0);
      to_next();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/wb_sdram_mport.md
WB_SDRAM_MPORT -- requirements
Module: wb_sdram_mport

Interface
REQ-001 SHALL have parameter N_PORTS, default 2: number of Wishbone slave ports (1..16).
REQ-002 SHALL have parameter ADDR_BITS, default 23: address width (BANK+ROW+COL of wb_sdram).
REQ-003 SHALL have parameter DATA_BYTES, default 2: data width is DATA_BYTES*8.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 8: depth of the in-flight ID FIFO (1..64, any integer).
REQ-005 SHALL have port clk, input, 1: the single clock; all logic on rising edge.
REQ-006 SHALL have port sreset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have ports s_wb_addr/s_wb_dat_m2s, input, N_PORTS*ADDR_BITS / N_PORTS*DATA_BYTES*8: per-port request fields, port k in slice k.
REQ-008 SHALL have ports s_wb_we, s_wb_stb, input, N_PORTS each: per-port write enable and strobe.
REQ-009 SHALL have ports s_wb_ack, s_wb_stall, output, N_PORTS each; s_wb_dat_s2m, output, DATA_BYTES*8, shared by all ports.
REQ-010 SHALL have ports m_wb_addr, m_wb_dat_m2s, m_wb_we, m_wb_stb, output, and m_wb_dat_s2m, m_wb_ack, m_wb_stall, input, toward wb_sdram.
REQ-011 SHALL have port err_ack, output, 1: sticky flag, ack received with no transaction in flight.

Function
REQ-012 SHALL arbitrate combinationally each cycle among ports with s_wb_stb=1; grant = first requester searching upward (with wrap) from last_grant+1.
REQ-013 SHALL drive m_wb_stb = s_wb_stb[grant] && !fifo_full, and m_wb_addr/dat_m2s/we from the granted port; m_wb_stb=0 when no requester.
REQ-014 SHALL drive s_wb_stall[grant] = m_wb_stall || fifo_full; all non-granted ports stall=1.
REQ-015 SHALL treat a transfer as accepted when m_wb_stb && !m_wb_stall; on accept, push grant index into ID FIFO and set last_grant=grant at next edge.
REQ-016 SHALL, on m_wb_ack with FIFO non-empty, assert s_wb_ack[head] in the same cycle (zero latency) and pop the FIFO.
REQ-017 SHALL drive s_wb_dat_s2m = m_wb_dat_s2m continuously; only the acked port samples it.
REQ-018 SHALL support simultaneous push and pop in one cycle, occupancy unchanged; pop-then-push ordering preserved.
REQ-019 SHALL, when FIFO holds MAX_OUTSTANDING entries, stall all ports until a pop; an ack while full frees a slot from the next cycle.
REQ-020 SHALL, on m_wb_ack with FIFO empty, assert no s_wb_ack and set err_ack=1 at the next edge; it stays set until reset.
REQ-021 SHALL require the downstream slave never acks in the accept cycle; acks complete in acceptance order.
REQ-022 SHALL add zero request latency and zero response latency; with one continuous requester and no stall, sustain one transfer per cycle.

Reset
REQ-023 SHALL on sreset=1 at an edge: FIFO empty, last_grant=N_PORTS-1 (port 0 wins first), err_ack=0.
REQ-024 SHALL, during reset, drive m_wb_stb=0, all s_wb_ack=0, all s_wb_stall=1.
REQ-025 SHALL discard in-flight IDs on reset mid-operation; later stray acks set err_ack per REQ-020.

Configuration
REQ-026 SHALL, with WB_SDRAM_MPORT_FIXED_PRIO_EN defined, use fixed priority: lowest-index requesting port always wins, last_grant unused.
REQ-027 SHALL, without WB_SDRAM_MPORT_FIXED_PRIO_EN, use round-robin per REQ-012.

Verification
REQ-028 SHALL test: N_PORTS=2, both stb=1 held 4 cycles, no stall -> round-robin grants 0,1,0,1; fixed-prio build -> 0,0,0,0.
REQ-029 SHALL test: port1 writes 16'h5555 to addr 0, port0 reads addr 0 -> port0 ack with dat 16'h5555, port1 ack only for its write.
REQ-030 SHALL test: MAX_OUTSTANDING=2, slave withholds ack, 3 requests -> third stalled until first ack, then accepted next cycle.
REQ-031 SHALL test: ack and new accept in same cycle at occupancy 1 -> occupancy stays 1, acks routed in order.
REQ-032 SHALL test: m_wb_ack pulse with empty FIFO -> no s_wb_ack, err_ack=1 next cycle, cleared only by sreset.
REQ-033 SHALL test: sreset asserted with 3 in flight -> FIFO empty, first post-reset grant to port 0.
